// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the time-multiplexed pattern detector.
// The fallback table is built once from the pattern and indexed by (prefix length, bit).
package seq_det_pkg;

   localparam int FB_EW  = 4;  // bits per fallback entry, enough for PAT_LEN up to 8
   localparam int FB_MAX = 8;

   typedef logic [2*FB_MAX*FB_EW-1:0] fb_t;

   function automatic int state_width(input int pat_len);
      return $clog2(pat_len + 1);
   endfunction

   function automatic int chan_width(input int n_ch);
      return (n_ch <= 2) ? 1 : $clog2(n_ch);
   endfunction

   function automatic int det_state(input int pat_len);
      return pat_len;
   endfunction

   // Entry (k,b): longest pattern prefix that is a proper suffix of (first k pattern bits, b).
   function automatic fb_t fb_table(input logic [FB_MAX-1:0] pattern, input int pat_len);
      fb_t             tbl;
      logic [FB_MAX:0] s;
      bit              ok;
      int              best;
      tbl = '0;
      for (int k = 0; k < pat_len; k++) begin
         for (int b = 0; b < 2; b++) begin
            s = '0;
            for (int i = 0; i < k; i++) s[i] = pattern[pat_len-1-i];
            s[k] = b[0];
            best = 0;
            for (int l = k; l >= 1; l--) begin
               if (best == 0) begin
                  ok = 1'b1;
                  for (int i = 0; i < l; i++)
                     if (pattern[pat_len-1-i] != s[k+1-l+i]) ok = 1'b0;
                  if (ok) best = l;
               end
            end
            tbl[(k*2+b)*FB_EW +: FB_EW] = FB_EW'(best);
         end
      end
      return tbl;
   endfunction

endpackage

// File: rtl/seq_det_scheduler_if.sv
// Channel-side bundle of the shared pattern detector plus state visibility for checkers.
interface seq_det_scheduler_if #(
   parameter int N_CH = 4,
   parameter int CW   = 2,
   parameter int SW   = 3
);
   // A bit on channel i is consumed in a cycle where in_valid[i] and in_ready[i] are both 1;
   // in_ready is one-hot or zero and never asserts without the matching in_valid.
   logic [N_CH-1:0]          in_valid;
   logic [N_CH-1:0]          in_bit;
   logic [N_CH-1:0]          in_ready;
   logic [N_CH-1:0]          clear_ch;
   logic                     det_valid;
   logic [CW-1:0]            det_ch;
   logic [N_CH-1:0][SW-1:0]  state_dbg;
   logic                     moore_dbg;

   modport master (
      output in_valid, in_bit, clear_ch,
      input  in_ready, det_valid, det_ch, state_dbg, moore_dbg
   );

   modport slave (
      input  in_valid, in_bit, clear_ch,
      output in_ready, det_valid, det_ch, state_dbg, moore_dbg
   );
endinterface

// File: rtl/seq_det_core.sv
// Combinational next-state logic of the non-overlapping Moore detector; one copy is
// time-shared by all channels.
module seq_det_core
   import seq_det_pkg::*;
#(
   parameter int               PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1110,
   localparam int              SW      = state_width(PAT_LEN)
) (
   input  logic [SW-1:0] state_in,
   input  logic          bit_in,
   output logic [SW-1:0] state_nxt,
   output logic          moore_out
);

   localparam fb_t           FB  = fb_table(FB_MAX'(PATTERN), PAT_LEN);
   localparam logic [SW-1:0] DET = SW'(det_state(PAT_LEN));

   logic [SW-1:0] eff;

   // DET restarts like S0; encodings above DET match no k and fall to S0.
   always_comb begin
      eff       = (state_in == DET) ? '0 : state_in;
      state_nxt = '0;
      for (int k = 0; k < PAT_LEN; k++) begin
         if (eff == SW'(k)) begin
            if (bit_in == PATTERN[PAT_LEN-1-k])
               state_nxt = SW'(k + 1);
            else if (bit_in)
               state_nxt = SW'(FB[(k*2+1)*FB_EW +: FB_EW]);
            else
               state_nxt = SW'(FB[(k*2)*FB_EW +: FB_EW]);
         end
      end
   end

   assign moore_out = (state_in == DET);

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler that steps one channel per cycle through a shared detector core
// and reports completed patterns as a registered, channel-tagged pulse.
module seq_det_scheduler
   import seq_det_pkg::*;
#(
   parameter int                 N_CH    = 4,
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1110,
   localparam int                SW      = state_width(PAT_LEN),
   localparam int                CW      = chan_width(N_CH)
) (
   input logic               clk,
   input logic               rst_n,
   seq_det_scheduler_if.slave bus
);

   localparam logic [SW-1:0] DET = SW'(det_state(PAT_LEN));

   logic [SW-1:0]   state_q [N_CH];
   logic [CW-1:0]   ptr_q;
   logic            det_valid_q;
   logic [CW-1:0]   det_ch_q;

   logic [N_CH-1:0] grant;
   logic [CW-1:0]   gidx;
   logic            found;
   logic [CW-1:0]   ptr_nxt;
   logic [SW-1:0]   cur_state;
   logic            cur_bit;
   logic [SW-1:0]   state_nxt;
   logic            moore_out;
   logic            det_hit;
   int              idx;

   // First valid channel at or after the pointer, wrapping modulo N_CH.
   always_comb begin
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N_CH; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!found && bus.in_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            gidx       = CW'(idx);
         end
      end
   end

   assign ptr_nxt   = (int'(gidx) == N_CH - 1) ? '0 : gidx + CW'(1);
   assign cur_state = state_q[gidx];
   assign cur_bit   = bus.in_bit[gidx];

   seq_det_core #(
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN)
   ) u_core (
      .state_in  (cur_state),
      .bit_in    (cur_bit),
      .state_nxt (state_nxt),
      .moore_out (moore_out)
   );

   // A clear on the granted channel swallows the bit and any detection it would cause.
   assign det_hit = found && !bus.clear_ch[gidx] && (state_nxt == DET);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) state_q[i] <= '0;
         ptr_q       <= '0;
         det_valid_q <= 1'b0;
         det_ch_q    <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (bus.clear_ch[i])
               state_q[i] <= '0;
            else if (grant[i])
               state_q[i] <= state_nxt;
         end
         if (found) ptr_q <= ptr_nxt;
         det_valid_q <= det_hit;
         if (det_hit) det_ch_q <= gidx;
      end
   end

   assign bus.in_ready  = grant;
   assign bus.det_valid = det_valid_q;
   assign bus.det_ch    = det_ch_q;
   assign bus.moore_dbg = moore_out;

   for (genvar g = 0; g < N_CH; g++) begin : g_dbg
      assign bus.state_dbg[g] = state_q[g];
   end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler: directed scenarios plus random traffic against a
// history-based detector model and a round-robin grant model.
module tb_seq_det_scheduler;

   localparam int         N   = 4;
   localparam int         PL  = 4;
   localparam int         CW  = 2;
   localparam int         SW  = 3;
   localparam logic [3:0] PAT = 4'b1110;

   logic clk;
   logic rst_n;

   seq_det_scheduler_if #(.N_CH(N), .CW(CW), .SW(SW)) bus ();

   seq_det_scheduler #(.N_CH(N), .PAT_LEN(PL), .PATTERN(PAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // model: per-channel bit history since last restart, newest bit in the LSB
   logic [7:0]    m_hist [N];
   int            m_cnt  [N];
   bit            m_det  [N];
   int            m_ptr;
   int            m_g;
   logic [CW:0]   exp_q[$];
   int            total = 0;
   int            bad   = 0;
   int            n_det;
   int            cyc   = 0;
   int            det_log[$];
   int            det_cyc[$];

   function automatic int exp_state(int i);
      if (m_det[i]) return PL;
      for (int l = PL - 1; l >= 1; l--)
         if (m_cnt[i] >= l && (m_hist[i] & 8'((1 << l) - 1)) == 8'(PAT >> (PL - l)))
            return l;
      return 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_hist[i] = '0;
         m_cnt[i]  = 0;
         m_det[i]  = 1'b0;
      end
      m_ptr = 0;
      exp_q.delete();
   endtask

   // entered shortly after a rising edge; returns 1 time unit after the next one
   task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] b, input logic [N-1:0] c);
      logic [N-1:0] eg;
      logic [CW:0]  e;
      bit           hit;
      bus.in_valid = v;
      bus.in_bit   = b;
      bus.clear_ch = c;
      @(negedge clk);
      m_g = -1;
      eg  = '0;
      for (int i = 0; i < N; i++) begin
         int id;
         id = (m_ptr + i) % N;
         if (m_g < 0 && v[id]) m_g = id;
      end
      if (m_g >= 0) eg[m_g] = 1'b1;
      total++;
      if (bus.in_ready !== eg) begin
         bad++;
         $display("FAIL grant cyc=%0d: in_ready=%b want %b", cyc, bus.in_ready, eg);
      end
      total++;
      if (bus.moore_dbg !== m_det[(m_g >= 0) ? m_g : 0]) begin
         bad++;
         $display("FAIL moore cyc=%0d: got %b want %b", cyc, bus.moore_dbg, m_det[(m_g >= 0) ? m_g : 0]);
      end
      hit = 1'b0;
      if (m_g >= 0) begin
         if (!c[m_g]) begin
            m_det[m_g]  = 1'b0;
            m_hist[m_g] = {m_hist[m_g][6:0], b[m_g]};
            if (m_cnt[m_g] < 8) m_cnt[m_g]++;
            if (m_cnt[m_g] >= PL && m_hist[m_g][PL-1:0] == PAT) begin
               hit         = 1'b1;
               m_det[m_g]  = 1'b1;
               m_hist[m_g] = '0;
               m_cnt[m_g]  = 0;
            end
         end
         m_ptr = (m_g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
         if (c[i]) begin
            m_hist[i] = '0;
            m_cnt[i]  = 0;
            m_det[i]  = 1'b0;
         end
      end
      exp_q.push_back({hit, hit ? CW'(m_g) : CW'(0)});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      total++;
      if (bus.det_valid !== e[CW]) begin
         bad++;
         $display("FAIL det_valid cyc=%0d: got %b want %b", cyc, bus.det_valid, e[CW]);
      end
      if (e[CW]) begin
         total++;
         if (bus.det_ch !== e[CW-1:0]) begin
            bad++;
            $display("FAIL det_ch cyc=%0d: got %0d want %0d", cyc, bus.det_ch, e[CW-1:0]);
         end
      end
      if (bus.det_valid === 1'b1) begin
         n_det++;
         det_log.push_back(int'(bus.det_ch));
         det_cyc.push_back(cyc);
      end
      for (int i = 0; i < N; i++) begin
         total++;
         if (bus.state_dbg[i] !== SW'(exp_state(i))) begin
            bad++;
            $display("FAIL state%0d cyc=%0d: got %0d want %0d", i, cyc, bus.state_dbg[i], exp_state(i));
         end
      end
      cyc++;
   endtask

   task automatic send(input int ch, input logic bv);
      cycle(N'(1) << ch, N'(bv) << ch, '0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle('0, '0, '0);
   endtask

   task automatic begin_test();
      n_det = 0;
      det_log.delete();
      det_cyc.delete();
   endtask

   task automatic check_count(input string name, input int want);
      total++;
      if (n_det != want) begin
         bad++;
         $display("FAIL %s: pulses=%0d want %0d", name, n_det, want);
      end
   endtask

   task automatic apply_reset();
      bus.in_valid = '0;
      bus.in_bit   = '0;
      bus.clear_ch = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      bus.in_valid = '0;
      bus.in_bit   = '0;
      bus.clear_ch = '0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (bus.det_valid !== 1'b0 || bus.det_ch !== '0) begin
         bad++;
         $display("FAIL reset_out: det_valid=%b det_ch=%0d want 0 0", bus.det_valid, bus.det_ch);
      end
      total++;
      if (bus.in_ready !== 4'b0000) begin
         bad++;
         $display("FAIL reset_ready_idle: got %b want 0000", bus.in_ready);
      end
      bus.in_valid = 4'b1111;
      #1;
      total++;
      if (bus.in_ready !== 4'b0001) begin
         bad++;
         $display("FAIL reset_ptr: in_ready=%b want 0001", bus.in_ready);
      end
      for (int i = 0; i < N; i++) begin
         total++;
         if (bus.state_dbg[i] !== '0) begin
            bad++;
            $display("FAIL reset_state%0d: got %0d want 0", i, bus.state_dbg[i]);
         end
      end
      bus.in_valid = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_single_ch0();
      logic [3:0] seq;
      begin_test();
      seq = 4'b1110;
      for (int i = 3; i >= 0; i--) send(0, seq[i]);
      idle(2);
      check_count("single_ch0_count", 1);
      total++;
      if (det_log.size() != 1 || det_log[0] != 0 || det_cyc[0] != cyc - 3) begin
         bad++;
         $display("FAIL single_ch0_tag: pulses=%0d want one on ch0 after 4th bit", det_log.size());
      end
   endtask

   task automatic test_self_loop();
      logic [4:0] seq;
      logic [2:0] tail;
      begin_test();
      seq = 5'b11110;
      for (int i = 4; i >= 0; i--) send(2, seq[i]);
      idle(1);
      check_count("self_loop_count", 1);
      tail = 3'b110;
      for (int i = 2; i >= 0; i--) send(2, tail[i]);
      idle(1);
      check_count("self_loop_tail", 1);
   endtask

   task automatic test_non_overlap();
      logic [6:0] seq;
      begin_test();
      seq = 7'b1110110;
      for (int i = 6; i >= 0; i--) send(1, seq[i]);
      idle(1);
      check_count("non_overlap_count", 1);
   endtask

   task automatic test_all_channels();
      int         sent [N];
      logic [N-1:0] b;
      logic [3:0] seq;
      seq = 4'b1110;
      apply_reset();
      begin_test();
      for (int i = 0; i < N; i++) sent[i] = 0;
      for (int t = 0; t < 4 * N; t++) begin
         for (int i = 0; i < N; i++) b[i] = (sent[i] < 4) ? seq[3-sent[i]] : 1'b0;
         cycle('1, b, '0);
         if (m_g >= 0) sent[m_g]++;
      end
      idle(1);
      check_count("all_ch_count", 4);
      total++;
      if (det_log.size() != 4 || det_log[0] != 0 || det_log[1] != 1 || det_log[2] != 2 ||
          det_log[3] != 3 || det_cyc[3] != det_cyc[0] + 3) begin
         bad++;
         $display("FAIL all_ch_order: got %0d pulses, want ch 0,1,2,3 consecutive", det_log.size());
      end
   endtask

   task automatic test_clear();
      logic [3:0] seq;
      begin_test();
      for (int i = 0; i < 3; i++) send(3, 1'b1);
      cycle(4'b1000, 4'b0000, 4'b1000);
      total++;
      if (bus.state_dbg[3] !== '0) begin
         bad++;
         $display("FAIL clear_state: got %0d want 0", bus.state_dbg[3]);
      end
      idle(1);
      check_count("clear_no_pulse", 0);
      seq = 4'b1110;
      for (int i = 3; i >= 0; i--) send(3, seq[i]);
      idle(1);
      check_count("clear_then_pattern", 1);
      total++;
      if (det_log.size() != 1 || det_log[0] != 3) begin
         bad++;
         $display("FAIL clear_tag: pulses=%0d want one on ch3", det_log.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] seq;
      begin_test();
      send(0, 1'b1);
      send(0, 1'b1);
      bus.in_valid = 4'b0001;
      bus.in_bit   = 4'b0001;
      #3;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.det_valid !== 1'b0 || bus.det_ch !== '0 || bus.state_dbg[0] !== '0) begin
         bad++;
         $display("FAIL mid_reset_async: det_valid=%b det_ch=%0d st0=%0d want 0 0 0",
                  bus.det_valid, bus.det_ch, bus.state_dbg[0]);
      end
      @(posedge clk);
      #1;
      total++;
      if (bus.det_valid !== 1'b0 || bus.state_dbg[0] !== '0) begin
         bad++;
         $display("FAIL mid_reset_hold: det_valid=%b st0=%0d want 0 0", bus.det_valid, bus.state_dbg[0]);
      end
      bus.in_valid = '0;
      bus.in_bit   = '0;
      rst_n = 1'b1;
      model_reset();
      send(0, 1'b1);
      send(0, 1'b0);
      idle(1);
      check_count("mid_reset_partial", 0);
      seq = 4'b1110;
      for (int i = 3; i >= 0; i--) send(0, seq[i]);
      idle(1);
      check_count("mid_reset_full", 1);
   endtask

   task automatic test_random();
      logic [N-1:0] v;
      logic [N-1:0] b;
      logic [N-1:0] c;
      begin_test();
      for (int t = 0; t < 400; t++) begin
         v = N'($urandom_range(0, 15));
         for (int i = 0; i < N; i++) b[i] = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 11) == 0) ? N'($urandom_range(0, 15)) : '0;
         cycle(v, b, c);
      end
      idle(1);
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.in_valid = '0;
      bus.in_bit   = '0;
      bus.clear_ch = '0;
      test_reset();
      test_single_ch0();
      test_self_loop();
      test_non_overlap();
      test_all_channels();
      test_clear();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
